// File: rtl/dmi_reg_adapter.sv
// Bridges DMI request/response transactions onto a simple req/ack register port.
// Optional ACCESS timeout is built when DMI_REG_ADAPTER_TIMEOUT_EN is defined.
module dmi_reg_adapter #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_ack_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i
);

    localparam int unsigned AddrW = 7;
    localparam int unsigned DataW = 32;
    localparam int unsigned OpW   = 2;

    localparam logic [OpW-1:0] OpNop   = 2'd0;
    localparam logic [OpW-1:0] OpRead  = 2'd1;
    localparam logic [OpW-1:0] OpWrite = 2'd2;
    localparam logic [1:0]     RespOk   = 2'd0;
    localparam logic [1:0]     RespFail = 2'd2;

    if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout
        $error("dmi_reg_adapter: TimeoutCycles must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [AddrW-1:0] req_addr;
    logic [DataW-1:0] req_data;
    logic [OpW-1:0]   req_op;
    logic             req_fire;
    logic             timeout_c;

    logic             ready_q,      ready_d;
    logic             reg_req_q,    reg_req_d;
    logic             reg_we_q,     reg_we_d;
    logic [AddrW-1:0] reg_addr_q,   reg_addr_d;
    logic [DataW-1:0] reg_wdata_q,  reg_wdata_d;
    logic [DataW-1:0] resp_data_q,  resp_data_d;
    logic [1:0]       resp_code_q,  resp_code_d;
    logic             resp_valid_q, resp_valid_d;

    assign req_addr = dmi_req_i[40:34];
    assign req_data = dmi_req_i[33:2];
    assign req_op   = dmi_req_i[1:0];
    assign req_fire = dmi_req_valid_i & ready_q;

`ifdef DMI_REG_ADAPTER_TIMEOUT_EN
    // Counter sits at zero outside ACCESS, so it restarts on every ACCESS entry.
    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);
    logic [7:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else if (state_q != ACCESS) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign timeout_c = (cnt_q == TimeoutLast);
`else
    assign timeout_c = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            reg_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            resp_data_q  <= '0;
            resp_code_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            reg_req_q    <= reg_req_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            resp_data_q  <= resp_data_d;
            resp_code_q  <= resp_code_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = (req_op == OpRead || req_op == OpWrite) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (reg_ack_i || timeout_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; acknowledge beats a coincident timeout
    always_comb begin
        ready_d      = ready_q;
        reg_req_d    = reg_req_q;
        reg_we_d     = reg_we_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        resp_data_d  = resp_data_q;
        resp_code_d  = resp_code_q;
        resp_valid_d = resp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    ready_d = 1'b0;
                    case (req_op)
                        OpRead, OpWrite: begin
                            reg_req_d   = 1'b1;
                            reg_we_d    = (req_op == OpWrite);
                            reg_addr_d  = req_addr;
                            reg_wdata_d = req_data;
                        end
                        OpNop: begin
                            resp_data_d  = '0;
                            resp_code_d  = RespOk;
                            resp_valid_d = 1'b1;
                        end
                        default: begin
                            resp_data_d  = '0;
                            resp_code_d  = RespFail;
                            resp_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ACCESS: begin
                if (reg_ack_i) begin
                    reg_req_d    = 1'b0;
                    resp_data_d  = reg_we_q ? '0 : reg_rdata_i;
                    resp_code_d  = reg_err_i ? RespFail : RespOk;
                    resp_valid_d = 1'b1;
                end else if (timeout_c) begin
                    reg_req_d    = 1'b0;
                    resp_data_d  = '0;
                    resp_code_d  = RespFail;
                    resp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    ready_d      = 1'b1;
                end
            end
            default: begin
                reg_req_d    = 1'b0;
                resp_valid_d = 1'b0;
                ready_d      = 1'b1;
            end
        endcase
    end

    assign dmi_req_ready_o  = ready_q;
    assign dmi_resp_o       = {resp_data_q, resp_code_q};
    assign dmi_resp_valid_o = resp_valid_q;
    assign reg_req_o        = reg_req_q;
    assign reg_we_o         = reg_we_q;
    assign reg_addr_o       = reg_addr_q;
    assign reg_wdata_o      = reg_wdata_q;

endmodule

// File: tb/tb_dmi_reg_adapter.sv
// Directed self-checking bench for dmi_reg_adapter; the timeout case builds only
// when DMI_REG_ADAPTER_TIMEOUT_EN is defined.
module tb_dmi_reg_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [40:0] dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_ack_i;
    logic [31:0] reg_rdata_i;
    logic        reg_err_i;

    int n_checks = 0;
    int n_errors = 0;

    dmi_reg_adapter #(.TimeoutCycles(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .reg_req_o        (reg_req_o),
        .reg_we_o         (reg_we_o),
        .reg_addr_o       (reg_addr_o),
        .reg_wdata_o      (reg_wdata_o),
        .reg_ack_i        (reg_ack_i),
        .reg_rdata_i      (reg_rdata_i),
        .reg_err_i        (reg_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [40:0] mk_req(input logic [6:0] addr, input logic [31:0] data,
                                           input logic [1:0] op);
        return {addr, data, op};
    endfunction

    // Present one request for a single handshake edge
    task automatic issue(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] op);
        dmi_req_i       = mk_req(addr, data, op);
        dmi_req_valid_i = 1'b1;
        step();
        dmi_req_valid_i = 1'b0;
        dmi_req_i       = '0;
    endtask

    task automatic finish_resp();
        dmi_resp_ready_i = 1'b1;
        step();
        dmi_resp_ready_i = 1'b0;
        check_eq("resp_valid_after_hs", 64'(dmi_resp_valid_o), 64'd0);
        check_eq("ready_after_hs", 64'(dmi_req_ready_o), 64'd1);
    endtask

    initial begin
        rst_ni           = 1'b0;
        dmi_req_i        = '0;
        dmi_req_valid_i  = 1'b0;
        dmi_resp_ready_i = 1'b0;
        reg_ack_i        = 1'b0;
        reg_rdata_i      = '0;
        reg_err_i        = 1'b0;
        step();
        step();
        check_eq("rst_reg_req", 64'(reg_req_o), 64'd0);
        check_eq("rst_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
        check_eq("rst_resp", 64'(dmi_resp_o), 64'd0);
        check_eq("rst_addr_wdata", {25'd0, reg_addr_o, reg_wdata_o}, 64'd0);
        rst_ni = 1'b1;
        step();
        check_eq("ready_after_release", 64'(dmi_req_ready_o), 64'd1);

        // READ, acknowledged in the first ACCESS cycle
        issue(7'h10, 32'h0, 2'd1);
        check_eq("rd_req", 64'(reg_req_o), 64'd1);
        check_eq("rd_we", 64'(reg_we_o), 64'd0);
        check_eq("rd_addr", 64'(reg_addr_o), 64'h10);
        check_eq("rd_ready_low", 64'(dmi_req_ready_o), 64'd0);
        check_eq("rd_no_resp_yet", 64'(dmi_resp_valid_o), 64'd0);
        reg_ack_i   = 1'b1;
        reg_rdata_i = 32'hDEADBEEF;
        step();
        reg_ack_i   = 1'b0;
        reg_rdata_i = '0;
        check_eq("rd_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
        check_eq("rd_resp", 64'(dmi_resp_o), 64'h3_7AB6_FBBC);
        check_eq("rd_req_dropped", 64'(reg_req_o), 64'd0);
        finish_resp();

        // WRITE, ack in the 5th ACCESS cycle, then 3 cycles of response back-pressure
        issue(7'h04, 32'h12345678, 2'd2);
        for (int i = 0; i < 5; i++) begin
            check_eq("wr_req", 64'(reg_req_o), 64'd1);
            check_eq("wr_we", 64'(reg_we_o), 64'd1);
            check_eq("wr_addr", 64'(reg_addr_o), 64'h04);
            check_eq("wr_wdata", 64'(reg_wdata_o), 64'h12345678);
            check_eq("wr_ready_low", 64'(dmi_req_ready_o), 64'd0);
            reg_ack_i   = (i == 4);
            reg_rdata_i = 32'h9999_9999;
            step();
        end
        // Stray acknowledges during RESP must not disturb the held response
        reg_ack_i   = 1'b1;
        reg_rdata_i = 32'hFFFF_FFFF;
        reg_err_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("wr_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
            check_eq("wr_resp", 64'(dmi_resp_o), 64'd0);
            check_eq("wr_ready_low_resp", 64'(dmi_req_ready_o), 64'd0);
            check_eq("wr_req_low_resp", 64'(reg_req_o), 64'd0);
            step();
        end
        reg_ack_i   = 1'b0;
        reg_rdata_i = '0;
        reg_err_i   = 1'b0;
        check_eq("wr_resp_still", 64'(dmi_resp_valid_o), 64'd1);
        finish_resp();

        // NOP and reserved op never reach the register port
        issue(7'h01, 32'hAAAA5555, 2'd0);
        check_eq("nop_reg_req", 64'(reg_req_o), 64'd0);
        check_eq("nop_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
        check_eq("nop_resp", 64'(dmi_resp_o), 64'd0);
        finish_resp();
        issue(7'h02, 32'h5555AAAA, 2'd3);
        check_eq("op3_reg_req", 64'(reg_req_o), 64'd0);
        check_eq("op3_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
        check_eq("op3_resp", 64'(dmi_resp_o), 64'h2);
        finish_resp();

        // READ answered with an error keeps the read data
        issue(7'h22, 32'h0, 2'd1);
        reg_ack_i   = 1'b1;
        reg_err_i   = 1'b1;
        reg_rdata_i = 32'hCAFEF00D;
        step();
        reg_ack_i   = 1'b0;
        reg_err_i   = 1'b0;
        reg_rdata_i = '0;
        check_eq("err_resp", 64'(dmi_resp_o), 64'h3_2BFB_C036);
        finish_resp();

`ifdef DMI_REG_ADAPTER_TIMEOUT_EN
        // No acknowledge: 4 ACCESS cycles then a failed response
        issue(7'h33, 32'h0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("to_req_high", 64'(reg_req_o), 64'd1);
            step();
        end
        check_eq("to_req_dropped", 64'(reg_req_o), 64'd0);
        check_eq("to_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
        check_eq("to_resp", 64'(dmi_resp_o), 64'h2);
        finish_resp();
        // Acknowledge on the timeout cycle wins
        issue(7'h33, 32'h0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("to_ack_req_high", 64'(reg_req_o), 64'd1);
            reg_ack_i   = (i == 3);
            reg_rdata_i = 32'h00000055;
            step();
        end
        reg_ack_i   = 1'b0;
        reg_rdata_i = '0;
        check_eq("to_ack_resp", 64'(dmi_resp_o), 64'h154);
        finish_resp();
`else
        // Without the timeout the access waits indefinitely
        issue(7'h33, 32'h0, 2'd1);
        for (int i = 0; i < 20; i++) step();
        check_eq("wait_req_high", 64'(reg_req_o), 64'd1);
        check_eq("wait_no_resp", 64'(dmi_resp_valid_o), 64'd0);
        reg_ack_i   = 1'b1;
        reg_rdata_i = 32'h0BADC0DE;
        step();
        reg_ack_i   = 1'b0;
        reg_rdata_i = '0;
        check_eq("wait_resp", 64'(dmi_resp_o), 64'h0_2EB7_0378);
        finish_resp();
`endif

        // Reset during ACCESS abandons the transaction
        issue(7'h7F, 32'hFFFFFFFF, 2'd2);
        check_eq("mid_req_high", 64'(reg_req_o), 64'd1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check_eq("mid_rst_req", {62'd0, reg_req_o, reg_we_o}, 64'd0);
        check_eq("mid_rst_addr_wdata", {25'd0, reg_addr_o, reg_wdata_o}, 64'd0);
        check_eq("mid_rst_resp", {29'd0, dmi_resp_valid_o, dmi_resp_o}, 64'd0);
        check_eq("mid_rst_ready", 64'(dmi_req_ready_o), 64'd1);
        dmi_resp_ready_i = 1'b1;
        reg_ack_i        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("mid_no_resp", 64'(dmi_resp_valid_o), 64'd0);
            check_eq("mid_no_req", 64'(reg_req_o), 64'd0);
        end
        dmi_resp_ready_i = 1'b0;
        reg_ack_i        = 1'b0;
        check_eq("mid_ready_idle", 64'(dmi_req_ready_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
